mem_arbiter: RTL and testbench

Two-requester arbiter that shares one backing memory port between the fetch stage (imem, read-only) and the memory stage (dmem, read/write) of the rv32imc pipeline. Each requester issues single-cycle mask pulses and then stalls until its response. The arbiter captures each pulse in a one-entry pending buffer, grants the port round-robin, and routes the response back. It sits between the core's imem/dmem ports and the cache/memory model.

---
 rtl/rv32imc_types.sv | 29 ++
 rtl/mem_arbiter_checker.sv | 51 +++++
 rtl/mem_req_buffer.sv | 28 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32imc_types.sv
// Shared types for the rv32imc pipeline memory path.
// Holds the arbiter FSM state, grant identifiers and the request record.
package rv32imc_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } mem_grant_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_NONE = '{addr: 32'h0, rmask: 4'h0, wmask: 4'h0, wdata: 32'h0};

  function automatic logic req_valid(input mem_req_t req);
    return (req.rmask | req.wmask) != 4'h0;
  endfunction

endpackage

// File: rtl/mem_arbiter_checker.sv
// Protocol checks for mem_arbiter: duplicate requests, dmem read+write, stray responses.
// Violations are reported and counted; the arbiter itself ignores or repairs them.
module mem_arbiter_checker
  import rv32imc_types::*;
(
  input logic           clk,
  input logic           rst,
  input mem_arb_state_t state,
  input logic           busy_i,
  input logic           busy_d,
  input logic [3:0]     imem_rmask,
  input logic [3:0]     dmem_rmask,
  input logic [3:0]     dmem_wmask,
  input logic           mem_resp
);

  logic       first_r;
  logic [7:0] viol_cnt_r;
  logic       imem_dup_s, dmem_dup_s, dmem_rw_s, stray_resp_s, viol_s;

  // Decode each violation class.
  always_comb begin
    imem_dup_s   = (imem_rmask != 4'h0) && busy_i;
    dmem_dup_s   = ((dmem_rmask | dmem_wmask) != 4'h0) && busy_d;
    dmem_rw_s    = (dmem_rmask != 4'h0) && (dmem_wmask != 4'h0);
    stray_resp_s = mem_resp && (state == IDLE) && !first_r;
    viol_s       = imem_dup_s || dmem_dup_s || dmem_rw_s || stray_resp_s;
  end

  // First-cycle-after-reset marker and running violation count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_r    <= 1'b1;
      viol_cnt_r <= 8'h00;
    end else begin
      first_r    <= 1'b0;
      viol_cnt_r <= viol_cnt_r + {7'h00, viol_s};
    end
  end

  // Report each violation as it is seen.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!imem_dup_s) else $warning("mem_arbiter: imem request while busy, ignored");
      assert (!dmem_dup_s) else $warning("mem_arbiter: dmem request while busy, ignored");
      assert (!dmem_rw_s) else $warning("mem_arbiter: dmem rmask and wmask both set, write kept");
      assert (!stray_resp_s) else $warning("mem_arbiter: mem_resp with no outstanding request");
    end
  end

endmodule

// File: rtl/mem_req_buffer.sv
// One-entry request capture register with a pending flag.
// The captured record stays put after clr so the arbiter can keep driving it during the wait.
module mem_req_buffer
  import rv32imc_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     clr,
  input  mem_req_t cap_req,
  output logic     pend,
  output mem_req_t held_req
);

  // Pending flag and captured request record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      held_req <= MEM_REQ_NONE;
    end else if (clr) begin
      pend     <= 1'b0;
    end else if (load) begin
      pend     <= 1'b1;
      held_req <= cap_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the imem (fetch) and dmem requesters.
// Each requester pulse is captured, issued for one cycle, and the response routed back.
module mem_arbiter
  import rv32imc_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  mem_arb_state_t state_r, state_next_s;
  mem_grant_t     last_grant_r, last_grant_next_s;
  mem_req_t       imem_req_s, dmem_req_s, buf_i_s, buf_d_s, sel_req_s;
  logic           pend_i_s, pend_d_s, busy_i_s, busy_d_s, load_i_s, load_d_s;
  logic           issue_i_s, issue_d_s, drive_s, resp_i_s, resp_d_s;

  // Build request records; a dmem write drops any simultaneous read mask.
  always_comb begin
    imem_req_s = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
    dmem_req_s = '{addr: dmem_addr, rmask: (dmem_wmask != 4'h0) ? 4'h0 : dmem_rmask,
                   wmask: dmem_wmask, wdata: dmem_wdata};
    busy_i_s   = pend_i_s || (state_r == WAIT_I);
    busy_d_s   = pend_d_s || (state_r == WAIT_D);
    load_i_s   = req_valid(imem_req_s) && !busy_i_s;
    load_d_s   = req_valid(dmem_req_s) && !busy_d_s;
  end

  mem_req_buffer u_buf_i (
    .clk      (clk),
    .rst      (rst),
    .load     (load_i_s),
    .clr      (issue_i_s),
    .cap_req  (imem_req_s),
    .pend     (pend_i_s),
    .held_req (buf_i_s)
  );

  mem_req_buffer u_buf_d (
    .clk      (clk),
    .rst      (rst),
    .load     (load_d_s),
    .clr      (issue_d_s),
    .cap_req  (dmem_req_s),
    .pend     (pend_d_s),
    .held_req (buf_d_s)
  );

  // FSM state and tie-break history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GNT_I;
    end else begin
      state_r      <= state_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // Grant selection. last_grant remembers the winner of the latest contested grant, so
  // uncontested issues leave it alone and repeated ties alternate between the ports.
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    issue_i_s         = 1'b0;
    issue_d_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (pend_d_s && (!pend_i_s || (last_grant_r == GNT_I))) begin
          issue_d_s    = 1'b1;
          state_next_s = WAIT_D;
          if (pend_i_s) begin
            last_grant_next_s = GNT_D;
          end else begin
            last_grant_next_s = last_grant_r;
          end
        end else if (pend_i_s) begin
          issue_i_s    = 1'b1;
          state_next_s = WAIT_I;
          if (pend_d_s) begin
            last_grant_next_s = GNT_I;
          end else begin
            last_grant_next_s = last_grant_r;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_I: begin
        if (mem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_I;
        end
      end
      WAIT_D: begin
        if (mem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT_D;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Downstream drive and response routing; masks pulse only in the issue cycle.
  always_comb begin
    sel_req_s  = (issue_d_s || (state_r == WAIT_D)) ? buf_d_s : buf_i_s;
    drive_s    = issue_i_s || issue_d_s || (state_r != IDLE);
    mem_addr   = drive_s ? sel_req_s.addr : 32'h0;
    mem_wdata  = drive_s ? sel_req_s.wdata : 32'h0;
    mem_rmask  = (issue_i_s || issue_d_s) ? sel_req_s.rmask : 4'h0;
    mem_wmask  = (issue_i_s || issue_d_s) ? sel_req_s.wmask : 4'h0;
    resp_i_s   = (state_r == WAIT_I) && mem_resp;
    resp_d_s   = (state_r == WAIT_D) && mem_resp;
    imem_resp  = resp_i_s;
    dmem_resp  = resp_d_s;
    imem_rdata = resp_i_s ? mem_rdata : 32'h0;
    dmem_rdata = resp_d_s ? mem_rdata : 32'h0;
  end

  mem_arbiter_checker u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .busy_i     (busy_i_s),
    .busy_d     (busy_d_s),
    .imem_rmask (imem_rmask),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .mem_resp   (mem_resp)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: capture latency, round-robin ties, capture during wait,
// asynchronous reset mid-transaction and the illegal dmem read+write request.
module tb_mem_arbiter;

  logic        clk, rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;
  int          checks = 0;
  int          errors = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rmask (imem_rmask),
    .imem_rdata (imem_rdata),
    .imem_resp  (imem_resp),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_addr   (mem_addr),
    .mem_rmask  (mem_rmask),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic        first_d;
    logic [31:0] ia, da;

    rst        = 1'b1;
    imem_addr  = 32'h0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    mem_rdata  = 32'hA5A5_5A5A;
    mem_resp   = 1'b0;
    idle_inputs();

    // Reset state
    step();
    step();
    look();
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_rmask", {28'h0, mem_rmask}, 32'h0);
    check("rst mem_wmask", {28'h0, mem_wmask}, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst imem_resp", {31'h0, imem_resp}, 32'h0);
    check("rst dmem_resp", {31'h0, dmem_resp}, 32'h0);
    check("rst imem_rdata", imem_rdata, 32'h0);
    check("rst dmem_rdata", dmem_rdata, 32'h0);
    step();
    rst = 1'b0;

    // Single fetch with a 1-cycle memory
    step();
    imem_rmask = 4'hF;
    imem_addr  = 32'h0000_1000;
    look();
    check("fetch no bypass", {28'h0, mem_rmask}, 32'h0);
    step();
    idle_inputs();
    look();
    check("fetch issue rmask", {28'h0, mem_rmask}, 32'hF);
    check("fetch issue addr", mem_addr, 32'h0000_1000);
    check("fetch early resp", {31'h0, imem_resp}, 32'h0);
    step();
    mem_resp  = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    look();
    check("fetch imem_resp", {31'h0, imem_resp}, 32'h1);
    check("fetch imem_rdata", imem_rdata, 32'hDEAD_BEEF);
    check("fetch dmem_resp", {31'h0, dmem_resp}, 32'h0);
    step();
    mem_resp = 1'b0;
    look();
    check("fetch resp pulse", {31'h0, imem_resp}, 32'h0);
    check("fetch rdata idle", imem_rdata, 32'h0);

    // Simultaneous requests after reset: dmem wins the first tie
    do_reset();
    step();
    imem_rmask = 4'hF;
    imem_addr  = 32'h0000_2000;
    dmem_wmask = 4'hF;
    dmem_wdata = 32'h1234_5678;
    dmem_addr  = 32'h0000_8000;
    look();
    step();
    idle_inputs();
    look();
    check("sim d wmask", {28'h0, mem_wmask}, 32'hF);
    check("sim d wdata", mem_wdata, 32'h1234_5678);
    check("sim d addr", mem_addr, 32'h0000_8000);
    check("sim d rmask", {28'h0, mem_rmask}, 32'h0);
    step();
    mem_resp  = 1'b1;
    mem_rdata = 32'h0;
    look();
    check("sim dmem_resp", {31'h0, dmem_resp}, 32'h1);
    check("sim no imem_resp", {31'h0, imem_resp}, 32'h0);
    check("sim wait addr hold", mem_addr, 32'h0000_8000);
    step();
    mem_resp = 1'b0;
    look();
    check("sim i rmask", {28'h0, mem_rmask}, 32'hF);
    check("sim i addr", mem_addr, 32'h0000_2000);
    step();
    mem_resp  = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    look();
    check("sim imem_resp", {31'h0, imem_resp}, 32'h1);
    check("sim imem_rdata", imem_rdata, 32'h0BAD_F00D);
    step();
    mem_resp = 1'b0;

    // Round-robin: four tied pairs, tie winner alternates D,I,D,I
    do_reset();
    for (int p = 0; p < 4; p++) begin
      first_d = ((p % 2) == 0);
      ia = 32'h0000_3000 + 32'(p * 4);
      da = 32'h0000_9000 + 32'(p * 4);
      step();
      imem_rmask = 4'hF;
      imem_addr  = ia;
      dmem_rmask = 4'hF;
      dmem_addr  = da;
      look();
      step();
      idle_inputs();
      look();
      check("rr first addr", mem_addr, first_d ? da : ia);
      check("rr first rmask", {28'h0, mem_rmask}, 32'hF);
      step();
      mem_resp  = 1'b1;
      mem_rdata = 32'(p);
      look();
      check("rr first dmem_resp", {31'h0, dmem_resp}, {31'h0, first_d});
      check("rr first imem_resp", {31'h0, imem_resp}, {31'h0, ~first_d});
      step();
      mem_resp = 1'b0;
      look();
      check("rr second addr", mem_addr, first_d ? ia : da);
      step();
      mem_resp = 1'b1;
      look();
      check("rr second dmem_resp", {31'h0, dmem_resp}, {31'h0, ~first_d});
      step();
      mem_resp = 1'b0;
    end

    // Capture during wait: dmem sb with 5-cycle memory, imem pulse 2 cycles after dmem pulse
    step();
    dmem_wmask = 4'b0100;
    dmem_wdata = 32'h00AB_0000;
    dmem_addr  = 32'h0000_8004;
    look();
    step();
    idle_inputs();
    look();
    check("cap sb wmask", {28'h0, mem_wmask}, 32'h4);
    check("cap sb wdata", mem_wdata, 32'h00AB_0000);
    step();
    imem_rmask = 4'hF;
    imem_addr  = 32'h0000_4000;
    look();
    step();
    idle_inputs();
    look();
    check("cap held off", {28'h0, mem_rmask}, 32'h0);
    step();
    step();
    look();
    check("cap still held", {28'h0, mem_rmask}, 32'h0);
    check("cap addr hold", mem_addr, 32'h0000_8004);
    step();
    mem_resp = 1'b1;
    look();
    check("cap dmem_resp", {31'h0, dmem_resp}, 32'h1);
    check("cap no issue at resp", {28'h0, mem_rmask}, 32'h0);
    step();
    mem_resp = 1'b0;
    look();
    check("cap i rmask", {28'h0, mem_rmask}, 32'hF);
    check("cap i addr", mem_addr, 32'h0000_4000);
    step();
    mem_resp  = 1'b1;
    mem_rdata = 32'h1111_2222;
    look();
    check("cap imem_resp", {31'h0, imem_resp}, 32'h1);
    step();
    mem_resp = 1'b0;

    // Async reset while waiting on a fetch; late mem_resp is ignored
    step();
    imem_rmask = 4'hF;
    imem_addr  = 32'h0000_5000;
    look();
    step();
    idle_inputs();
    look();
    check("ar issue", {28'h0, mem_rmask}, 32'hF);
    step();
    look();
    check("ar wait addr", mem_addr, 32'h0000_5000);
    rst = 1'b1;
    #1;
    check("ar mem_addr", mem_addr, 32'h0);
    check("ar mem_rmask", {28'h0, mem_rmask}, 32'h0);
    check("ar mem_wdata", mem_wdata, 32'h0);
    check("ar imem_resp", {31'h0, imem_resp}, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    step();
    mem_resp  = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    look();
    check("ar late imem_resp", {31'h0, imem_resp}, 32'h0);
    check("ar late imem_rdata", imem_rdata, 32'h0);
    check("ar late dmem_resp", {31'h0, dmem_resp}, 32'h0);
    step();
    mem_resp = 1'b0;
    look();
    check("ar no reissue", {28'h0, mem_rmask}, 32'h0);

    // Illegal dmem request with rmask and wmask together: write wins, flagged
    do_reset();
    look();
    check("ill viol cleared", {24'h0, dut.u_chk.viol_cnt_r}, 32'h0);
    step();
    dmem_rmask = 4'hF;
    dmem_wmask = 4'h3;
    dmem_wdata = 32'h0000_BEEF;
    dmem_addr  = 32'h0000_8008;
    look();
    step();
    idle_inputs();
    look();
    check("ill wmask", {28'h0, mem_wmask}, 32'h3);
    check("ill rmask", {28'h0, mem_rmask}, 32'h0);
    check("ill addr", mem_addr, 32'h0000_8008);
    check("ill flagged", {24'h0, dut.u_chk.viol_cnt_r}, 32'h1);
    step();
    mem_resp = 1'b1;
    look();
    check("ill dmem_resp", {31'h0, dmem_resp}, 32'h1);
    step();
    mem_resp = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
